gcd_req_arbiter: RTL and testbench
==================================

// Module: gcd_req_arbiter
// PURPOSE
//  Shares one GCD engine between NREQ requesters. Requesters are served round-robin.
//  The block captures the granted operand pair and pulses the engine start.
//  It then waits for engine done and returns the result tagged with the requester id.
//  It sits between the client ports and the single gcd datapath instance.
// PARAMETERS
//  NREQ   4  number of requester ports; legal range 2..16
//  WIDTH  8  operand and result width in bits
//  IDW    $clog2(NREQ)  id width (localparam, derived)
// PORTS
//  clk          in   1           single clock, all state updates on posedge
//  reset        in   1           synchronous, active-high
//  req_valid    in   NREQ        per-requester operand pair valid
//  req_a        in   NREQ*WIDTH  operand a; slice i = [i*WIDTH +: WIDTH]
//  req_b        in   NREQ*WIDTH  operand b; same slicing as req_a
//  req_ready    out  NREQ        one-hot accept strobe; at most one bit high
//  eng_start    out  1           one-cycle start pulse to the engine
//  eng_a        out  WIDTH       operand a to engine; stable from start until done
//  eng_b        out  WIDTH       operand b to engine; stable from start until done
//  eng_done     in   1           engine result valid, sampled only in WAIT
//  eng_result   in   WIDTH       engine gcd result
//  rsp_valid    out  1           response valid
//  rsp_id       out  IDW         index of the requester served
//  rsp_result   out  WIDTH       gcd result
//  rsp_ready    in   1           response consumer ready
// BEHAVIOUR
//  Reset
//   - reset=1 at any posedge: state=IDLE, rr_ptr=0.
//   - All outputs 0: req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_result.
//   - Reset mid-operation discards the in-flight job; a late eng_done is ignored.
//   - The engine must share the same reset.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ-1 -> 0.
//   - req_ready[grant] is combinational and high only in IDLE with any valid.
//   - Handshake = req_valid[i] & req_ready[i] at a posedge. On handshake:
//     - latch req_a/req_b slices into eng_a/eng_b and grant into rsp_id;
//     - rr_ptr <= (grant==NREQ-1) ? 0 : grant+1;
//     - next state ISSUE.
//   - No valid: stay in IDLE. A requester may drop valid before grant; no penalty.
//  ISSUE
//   - eng_start=1 for exactly this one cycle, then WAIT.
//   - Accept-to-start latency: 1 cycle.
//  WAIT
//   - eng_start=0. On eng_done=1: rsp_result <= eng_result, rsp_valid <= 1, then RESP.
//   - No timeout; WAIT lasts indefinitely.
//  RESP
//   - rsp_valid, rsp_id and rsp_result are held stable until rsp_valid & rsp_ready.
//   - On that handshake: rsp_valid <= 0, state IDLE.
//   - Earliest next accept is the cycle after IDLE is re-entered.
//   - rsp_ready ignored outside RESP.
//  Timing
//   - Minimum turnaround = engine latency + 4 cycles.
//   - No overlap of jobs; exactly one job in flight.
//  Widths
//   - Operands are passed unmodified; no arithmetic is done on them here.
//   - rr_ptr is IDW bits and wraps explicitly for non-power-of-2 NREQ.
// CONFIGURATION
//  GCD_ZERO_BYPASS_EN
//   - Defined: in IDLE, a handshake with a==0 or b==0 skips ISSUE/WAIT.
//     rsp_result <= a|b (gcd(0,x)=x, gcd(0,0)=0); rsp_valid=1 the next cycle; eng_start never pulses.
//     rr_ptr and rsp_id update as normal.
//   - Undefined: zero operands are sent to the engine like any other pair.
// TESTING
//  1 Port0 a=48 b=18; engine model done after 5 cycles with 6
//    -> eng_start 1 cycle after accept, eng_a=48 eng_b=18; rsp_valid, id=0, result=6 cycle after done.
//  2 All 4 valid from reset, rsp_ready=1, constant pairs
//    -> grants in order 0,1,2,3,0,1; each req_ready one-hot.
//  3 rsp_ready held 0 for 10 cycles in RESP
//    -> rsp_* stable; req_ready all 0; eng_start 0; release -> IDLE next cycle.
//  4 reset pulsed in WAIT, then eng_done pulsed
//    -> all outputs 0; no rsp_valid; next grant starts at port 0.
//  5 Only port2 served, then ports 1 and 3 valid together
//    -> port3 granted first (rr_ptr=3), port1 next.
//  6 a=0 b=35 on port1
//    -> with GCD_ZERO_BYPASS_EN: rsp 35 id=1, no eng_start.
//    -> without: eng_start with eng_a=0 eng_b=35.

Source files
------------

// File: rtl/gcd_req_arbiter.sv
// gcd_req_arbiter: round-robin front end that shares one GCD engine between
// NREQ requesters. An accepted operand pair goes to the engine with a one-cycle
// start pulse. The engine result comes back tagged with the requester index.
//
// Optional feature macro: GCD_ZERO_BYPASS_EN
//   When defined, a pair with a zero operand is answered directly (a|b) and
//   the engine is never started for it.
module gcd_req_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    eng_start,
  output logic [WIDTH-1:0]        eng_a,
  output logic [WIDTH-1:0]        eng_b,
  input  logic                    eng_done,
  input  logic [WIDTH-1:0]        eng_result,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  input  logic                    rsp_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d;
  logic [WIDTH-1:0] eng_b_q, eng_b_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_valid_q, rsp_valid_d;

  // Per-port operand views and the rotated search order.
  logic [WIDTH-1:0] op_a     [NREQ];
  logic [WIDTH-1:0] op_b     [NREQ];
  logic [IDW:0]     cand_sum [NREQ];
  logic [IDW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0]  cand_vld;

  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic             zero_bypass;
  logic             accept;

  // Candidate gi is the port gi positions past rr_ptr, wrapping at NREQ so
  // that non-power-of-2 port counts never index a missing port.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign op_a[gi]     = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi]     = req_b[gi*WIDTH +: WIDTH];
    assign cand_sum[gi] = {1'b0, rr_ptr_q} + (IDW+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(NREQ))
                          ? IDW'(cand_sum[gi] - (IDW+1)'(NREQ))
                          : cand_sum[gi][IDW-1:0];
    assign cand_vld[gi] = req_valid[cand_idx[gi]];
  end

  // Pick the first valid candidate in round-robin order.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_vld[i]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  assign grant_a = op_a[grant_idx];
  assign grant_b = op_b[grant_idx];
  assign accept  = (state_q == ST_IDLE) && grant_valid;

  // Decide whether an accepted pair can skip the engine.
  always_comb begin
`ifdef GCD_ZERO_BYPASS_EN
    zero_bypass = (grant_a == '0) || (grant_b == '0);
`else
    zero_bypass = 1'b0;
`endif
  end

  // State register; reset discards any in-flight job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one job at a time through ISSUE/WAIT/RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_valid) state_d = zero_bypass ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done) state_d = ST_RESP;
      ST_RESP:  if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: accept strobe in IDLE, start pulse in ISSUE.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:  if (grant_valid) req_ready[grant_idx] = 1'b1;
        ST_ISSUE: eng_start = 1'b1;
        default:  ;
      endcase
    end
  end

  // Datapath next values: operand capture, pointer advance, response capture.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    if (accept) begin
      eng_a_d  = grant_a;
      eng_b_d  = grant_b;
      rsp_id_d = grant_idx;
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      if (zero_bypass) begin
        // gcd(0,x)=x and gcd(0,0)=0, so OR-ing the pair gives the answer.
        rsp_result_d = grant_a | grant_b;
        rsp_valid_d  = 1'b1;
      end
    end
    if ((state_q == ST_WAIT) && eng_done) begin
      rsp_result_d = eng_result;
      rsp_valid_d  = 1'b1;
    end
    if ((state_q == ST_RESP) && rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Testbench for gcd_req_arbiter (NREQ=4, WIDTH=8) with a behavioural engine.
module tb_gcd_req_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_a;
  logic [WIDTH-1:0]      eng_b;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_result;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gcd8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine model: done pulses eng_lat cycles after the start is seen.
  int         eng_lat = 5;
  int         eng_cnt;
  logic [7:0] eng_opa, eng_opb;
  logic       eng_done_m;
  logic [7:0] eng_result_m;
  logic       done_force = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      eng_cnt    <= 0;
      eng_done_m <= 1'b0;
    end else begin
      eng_done_m <= 1'b0;
      if (eng_start) begin
        eng_cnt <= eng_lat;
        eng_opa <= eng_a;
        eng_opb <= eng_b;
      end else if (eng_cnt == 1) begin
        eng_cnt      <= 0;
        eng_done_m   <= 1'b1;
        eng_result_m <= gcd8(eng_opa, eng_opb);
      end else if (eng_cnt > 1) begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign eng_done   = eng_done_m | done_force;
  assign eng_result = done_force ? 8'hAA : eng_result_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] spread(input logic [7:0] base, input int step);
    logic [31:0] r;
    for (int i = 0; i < NREQ; i++) r[i*8 +: 8] = base + 8'(step * i);
    return r;
  endfunction

  logic [7:0] last_rsp;

  // One full job: offer mask, expect grant exp_id, hold rsp_ready low for hold cycles.
  task automatic run_job(input logic [3:0] mask, input logic [31:0] av, input logic [31:0] bv,
                         input int exp_id, input int hold);
    logic [7:0] ea, eb, er, got_id, got_res;
    bit         byp, done_prev;
    int         c;
    ea = av[exp_id*8 +: 8];
    eb = bv[exp_id*8 +: 8];
    er = gcd8(ea, eb);
`ifdef GCD_ZERO_BYPASS_EN
    byp = (ea == 0) || (eb == 0);
`else
    byp = 1'b0;
`endif
    @(negedge clk);
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    #1;
    check("req_ready_onehot", 32'(req_ready), 32'(1 << exp_id));
    @(negedge clk);
    req_valid = '0;
    check("ready_after_accept", 32'(req_ready), 0);
    if (!byp) begin
      check("eng_start_pulse", 32'(eng_start), 1);
      check("eng_a", 32'(eng_a), 32'(ea));
      check("eng_b", 32'(eng_b), 32'(eb));
      check("rsp_valid_early", 32'(rsp_valid), 0);
    end else begin
      check("bypass_no_start", 32'(eng_start), 0);
      check("bypass_rsp_valid", 32'(rsp_valid), 1);
    end
    c = 0;
    done_prev = 1'b0;
    while (!rsp_valid && c < 200) begin
      done_prev = eng_done;
      @(negedge clk);
      c++;
      if (!rsp_valid) begin
        check("wait_no_start", 32'(eng_start), 0);
        check("wait_eng_a_stable", 32'(eng_a), 32'(ea));
      end
    end
    check("rsp_timeout", 32'(rsp_valid), 1);
    if (!byp) check("rsp_cycle_after_done", 32'(done_prev), 1);
    check("rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rsp_result", 32'(rsp_result), 32'(er));
    got_id  = 8'(rsp_id);
    got_res = rsp_result;
    for (int h = 0; h < hold; h++) begin
      req_valid = 4'hF;
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 1);
      check("hold_rsp_id", 32'(rsp_id), 32'(got_id));
      check("hold_rsp_result", 32'(rsp_result), 32'(got_res));
      check("hold_req_ready", 32'(req_ready), 0);
      check("hold_eng_start", 32'(eng_start), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", 32'(rsp_valid), 0);
    if (hold > 0) begin
      check("idle_after_release", 32'(req_ready), 32'(1 << ((exp_id + 1) % NREQ)));
      req_valid = '0;
    end
    last_rsp = rsp_result;
    $display("job mask=%b id=%0d a=%0d b=%0d result=%0d bypass=%0d", mask, exp_id, ea, eb, er, byp);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] a;
    logic [7:0] b;
    int         exp_id;
    int         hold;
  } vec_t;

  vec_t tbl [11];
  int   rr_model;

  initial begin
    logic [31:0] av, bv;
    logic [3:0]  mask;
    int          g;

    // Grant order from reset: 0,1,2,3,0,1 then port2 alone, then 1+3 twice.
    tbl[0]  = '{4'b1111, 8'd48, 8'd18, 0, 0};
    tbl[1]  = '{4'b1111, 8'd60, 8'd45, 1, 0};
    tbl[2]  = '{4'b1111, 8'd21, 8'd14, 2, 0};
    tbl[3]  = '{4'b1111, 8'd99, 8'd33, 3, 0};
    tbl[4]  = '{4'b1111, 8'd12, 8'd90, 0, 10};
    tbl[5]  = '{4'b1111, 8'd77, 8'd11, 1, 0};
    tbl[6]  = '{4'b0100, 8'd64, 8'd24, 2, 0};
    tbl[7]  = '{4'b1010, 8'd35, 8'd15, 3, 0};
    tbl[8]  = '{4'b1010, 8'd81, 8'd27, 1, 0};
    tbl[9]  = '{4'b0001, 8'd50, 8'd20, 0, 2};
    tbl[10] = '{4'b1001, 8'd17, 8'd51, 3, 0};

    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_eng_start", 32'(eng_start), 0);
    check("reset_eng_a", 32'(eng_a), 0);
    check("reset_eng_b", 32'(eng_b), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_result", 32'(rsp_result), 0);
    reset = 1'b0;

    // Port0 48/18 with a 5-cycle engine.
    eng_lat = 5;
    run_job(4'b0001, spread(8'd48, 5), spread(8'd18, 3), 0, 0);
    check("t1_result_is_6", 32'(last_rsp), 6);

    // Reset while waiting on the engine, then a stray done.
    eng_lat = 20;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a     = spread(8'd40, 1);
    req_b     = spread(8'd30, 1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait_eng_start", 32'(eng_start), 0);
    check("rst_wait_eng_a", 32'(eng_a), 0);
    check("rst_wait_rsp_valid", 32'(rsp_valid), 0);
    check("rst_wait_rsp_id", 32'(rsp_id), 0);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_done_ignored", 32'(rsp_valid), 0);
      check("late_done_no_start", 32'(eng_start), 0);
    end

    // Table-driven round-robin sequence starting from pointer 0.
    eng_lat = 3;
    for (int i = 0; i < 11; i++) begin
      run_job(tbl[i].mask, spread(tbl[i].a, 7), spread(tbl[i].b, 3), tbl[i].exp_id, tbl[i].hold);
    end

    // Zero operand on port1 (pointer is 0 after the table).
    av = '0;
    bv = '0;
    bv[15:8] = 8'd35;
    run_job(4'b0010, av, bv, 1, 0);
    check("t6_result_35", 32'(last_rsp), 35);
    rr_model = 2;

    // Randomized jobs against a plain round-robin model.
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int p = 0; p < NREQ; p++) begin
        av[p*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        bv[p*8 +: 8] = 8'($urandom_range(0, 255));
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && mask[(rr_model + k) % NREQ]) g = (rr_model + k) % NREQ;
      end
      eng_lat = $urandom_range(1, 6);
      run_job(mask, av, bv, g, $urandom_range(0, 2));
      rr_model = (g + 1) % NREQ;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
